// File: rtl/pcie_pio_dma_ctrl_if.sv
// Bus bundle between pcie_pio_dma_ctrl (master) and the pcie_rx/pcie_tx/core side (slave).
interface pcie_pio_dma_ctrl_if;
    logic        write_valid;
    logic        read_valid;
    logic        completion_valid;
    logic [63:0] rx_data;
    logic [12:0] rx_address;
    logic [23:0] rx_rid_tag;

    logic        read_completion_valid;
    logic [23:0] read_completion_rid_tag;
    logic [3:0]  read_completion_lower_addr;
    logic [63:0] read_completion_data;
    logic        read_completion_ready;

    logic        write_request_valid;
    logic [63:0] write_request_address;
    logic [63:0] write_request_data;
    logic        write_request_ready;

    logic        read_request_valid;
    logic [63:0] read_request_address;
    logic [7:0]  read_request_tag;
    logic        read_request_ready;

    logic        cfg_interrupt;
    logic [7:0]  cfg_interrupt_di;
    logic        cfg_interrupt_rdy;

    modport master (
        input  write_valid, read_valid, completion_valid, rx_data, rx_address, rx_rid_tag,
        input  read_completion_ready, write_request_ready, read_request_ready, cfg_interrupt_rdy,
        output read_completion_valid, read_completion_rid_tag, read_completion_lower_addr,
        output read_completion_data, write_request_valid, write_request_address,
        output write_request_data, read_request_valid, read_request_address, read_request_tag,
        output cfg_interrupt, cfg_interrupt_di
    );

    modport slave (
        output write_valid, read_valid, completion_valid, rx_data, rx_address, rx_rid_tag,
        output read_completion_ready, write_request_ready, read_request_ready, cfg_interrupt_rdy,
        input  read_completion_valid, read_completion_rid_tag, read_completion_lower_addr,
        input  read_completion_data, write_request_valid, write_request_address,
        input  write_request_data, read_request_valid, read_request_address, read_request_tag,
        input  cfg_interrupt, cfg_interrupt_di
    );
endinterface

// File: rtl/pcie_pio_dma_ctrl.sv
// PIO register file, read-completion queue and round-robin DMA/MSI request generator
// sitting between pcie_rx and pcie_tx.
module pcie_pio_dma_ctrl #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    parameter int LED_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    pcie_pio_dma_ctrl_if.master bus,
    output logic [LED_W-1:0]    led
);
    localparam int              CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [NCH-1:0]  CH_ONE  = NCH'(1'b1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

    typedef struct packed {
        logic [63:0] data;
        logic [23:0] rid;
        logic [3:0]  low;
    } cpl_t;

    // Returns {found, channel}: first pending channel at or after ptr, wrapping.
    function automatic logic [CH_W:0] rr_pick(input logic [NCH-1:0] pend, input logic [CH_W-1:0] ptr);
        logic [CH_W:0]   pick;
        logic [CH_W-1:0] idx;
        int              sum;
        pick = {(CH_W + 1){1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            sum = int'(ptr) + i;
            idx = (sum >= NCH) ? CH_W'(sum - NCH) : CH_W'(sum);
            if (pend[idx]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] c);
        return (c == CH_LAST) ? {CH_W{1'b0}} : c + CH_W'(1);
    endfunction

    logic [63:0]      scratch_r;
    logic [CNT_W-1:0] cpld_cnt_r, wr_cnt_r, rd_cnt_r;
    logic             overflow_r;
    logic [LED_W-1:0] led_r;
    logic [63:0]      ch_wr_addr_r [NCH];
    logic [63:0]      ch_rd_addr_r [NCH];
    logic [63:0]      ch_wr_data_r [NCH];
    logic [NCH-1:0]   wr_pend_r, rd_pend_r, irq_pend_r;

    logic             wr_req_valid_r, rd_req_valid_r, irq_valid_r;
    logic [63:0]      wr_req_addr_r, wr_req_data_r, rd_req_addr_r;
    logic [CH_W-1:0]  wr_gnt_r, rd_gnt_r, irq_gnt_r;
    logic [CH_W-1:0]  wr_ptr_r, rd_ptr_r, irq_ptr_r;

    logic             stg_valid_r, head_valid_r, tail_valid_r;
    cpl_t             stg_r, head_r, tail_r;

    logic             ch_hit_s, glb_wr_s;
    logic [CH_W-1:0]  ch_idx_s;
    logic [1:0]       ch_off_s;
    logic [NCH-1:0]   ch_sel_s;
    logic [NCH-1:0]   wr_set_s, rd_set_s, irq_set_s, wr_clr_s, rd_clr_s, irq_clr_s;
    logic [CH_W:0]    wr_pick_s, rd_pick_s, irq_pick_s;
    logic [63:0]      status_s, rd_mux_s;
    logic             pop_s, full_s, accept_s, ovf_set_s;

    // Channel window sits at QW 0x40 + 4*c; everything below 0x40 is the global page.
    assign ch_hit_s  = (bus.rx_address[12:5] == 8'd2) && (32'(bus.rx_address[4:2]) < NCH);
    assign ch_idx_s  = bus.rx_address[2 +: CH_W];
    assign ch_off_s  = bus.rx_address[1:0];
    assign ch_sel_s  = CH_ONE << ch_idx_s;
    assign glb_wr_s  = bus.write_valid && !ch_hit_s;

    assign wr_set_s  = (bus.write_valid && ch_hit_s && ch_off_s == 2'd0) ? ch_sel_s : {NCH{1'b0}};
    assign rd_set_s  = (bus.write_valid && ch_hit_s && ch_off_s == 2'd1) ? ch_sel_s : {NCH{1'b0}};
    assign irq_set_s = (bus.write_valid && ch_hit_s && ch_off_s == 2'd2) ? ch_sel_s : {NCH{1'b0}};
    assign wr_clr_s  = (wr_req_valid_r && bus.write_request_ready) ? (CH_ONE << wr_gnt_r) : {NCH{1'b0}};
    assign rd_clr_s  = (rd_req_valid_r && bus.read_request_ready) ? (CH_ONE << rd_gnt_r) : {NCH{1'b0}};
    assign irq_clr_s = (irq_valid_r && bus.cfg_interrupt_rdy) ? (CH_ONE << irq_gnt_r) : {NCH{1'b0}};

    assign wr_pick_s  = rr_pick(wr_pend_r, wr_ptr_r);
    assign rd_pick_s  = rr_pick(rd_pend_r, rd_ptr_r);
    assign irq_pick_s = rr_pick(irq_pend_r, irq_ptr_r);

    assign pop_s     = head_valid_r && bus.read_completion_ready;
    assign full_s    = head_valid_r && tail_valid_r;
    assign accept_s  = stg_valid_r && (!full_s || pop_s);
    assign ovf_set_s = stg_valid_r && full_s && !pop_s;

    // Status word: overflow at bit 63, pending vectors packed upward from bit 0.
    always_comb begin
        status_s                = 64'd0;
        status_s[63]            = overflow_r;
        status_s[0 +: NCH]      = wr_pend_r;
        status_s[NCH +: NCH]    = rd_pend_r;
        status_s[2*NCH +: NCH]  = irq_pend_r;
    end

    // Read data mux; unmapped addresses echo the address above a DEADBEEF marker.
    always_comb begin
        rd_mux_s = {19'd0, bus.rx_address, 32'hDEADBEEF};
        if (ch_hit_s) begin
            case (ch_off_s)
                2'd0:    rd_mux_s = ch_wr_addr_r[ch_idx_s];
                2'd1:    rd_mux_s = ch_rd_addr_r[ch_idx_s];
                2'd2:    rd_mux_s = {63'd0, irq_pend_r[ch_idx_s]};
                default: rd_mux_s = ch_wr_data_r[ch_idx_s];
            endcase
        end else begin
            case (bus.rx_address)
                13'd0:   rd_mux_s = scratch_r;
                13'd1:   rd_mux_s = 64'(cpld_cnt_r);
                13'd2:   rd_mux_s = 64'(wr_cnt_r);
                13'd3:   rd_mux_s = 64'(rd_cnt_r);
                13'd4:   rd_mux_s = status_s;
                13'd5:   rd_mux_s = 64'(led_r);
                default: rd_mux_s = {19'd0, bus.rx_address, 32'hDEADBEEF};
            endcase
        end
    end

    // Register file, traffic counters, pending bits and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_r  <= 64'd0;
            cpld_cnt_r <= {CNT_W{1'b0}};
            wr_cnt_r   <= {CNT_W{1'b0}};
            rd_cnt_r   <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
            led_r      <= {LED_W{1'b0}};
            wr_pend_r  <= {NCH{1'b0}};
            rd_pend_r  <= {NCH{1'b0}};
            irq_pend_r <= {NCH{1'b0}};
            for (int c = 0; c < NCH; c++) begin
                ch_wr_addr_r[c] <= 64'd0;
                ch_rd_addr_r[c] <= 64'd0;
                ch_wr_data_r[c] <= 64'd0;
            end
        end else begin
            cpld_cnt_r <= cpld_cnt_r + CNT_W'(bus.completion_valid);
            wr_cnt_r   <= wr_cnt_r + CNT_W'(bus.write_valid);
            rd_cnt_r   <= rd_cnt_r + CNT_W'(bus.read_valid);
            // Set after clear: a re-arm landing with the grant's handshake stays pending.
            wr_pend_r  <= (wr_pend_r & ~wr_clr_s) | wr_set_s;
            rd_pend_r  <= (rd_pend_r & ~rd_clr_s) | rd_set_s;
            irq_pend_r <= (irq_pend_r & ~irq_clr_s) | irq_set_s;
            if (bus.write_valid && ch_hit_s) begin
                case (ch_off_s)
                    2'd0:    ch_wr_addr_r[ch_idx_s] <= bus.rx_data;
                    2'd1:    ch_rd_addr_r[ch_idx_s] <= bus.rx_data;
                    2'd3:    ch_wr_data_r[ch_idx_s] <= bus.rx_data;
                    default: ;
                endcase
            end
            if (glb_wr_s && bus.rx_address == 13'd0) begin
                scratch_r <= bus.rx_data;
            end else if (bus.completion_valid) begin
                scratch_r <= bus.rx_data;
            end
            if (glb_wr_s && bus.rx_address == 13'd5) begin
                led_r <= bus.rx_data[LED_W-1:0];
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (glb_wr_s && bus.rx_address == 13'd4 && bus.rx_data[63]) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Read pipeline stage plus two-entry completion queue (head drives the outputs).
    always_ff @(posedge clock) begin
        if (reset) begin
            stg_valid_r  <= 1'b0;
            stg_r        <= '{64'd0, 24'd0, 4'd0};
            head_valid_r <= 1'b0;
            head_r       <= '{64'd0, 24'd0, 4'd0};
            tail_valid_r <= 1'b0;
            tail_r       <= '{64'd0, 24'd0, 4'd0};
        end else begin
            stg_valid_r <= bus.read_valid;
            stg_r       <= '{rd_mux_s, bus.rx_rid_tag, bus.rx_address[3:0]};
            if (pop_s) begin
                if (tail_valid_r) begin
                    head_r       <= tail_r;
                    tail_valid_r <= accept_s;
                    if (accept_s) tail_r <= stg_r;
                end else begin
                    head_valid_r <= accept_s;
                    if (accept_s) head_r <= stg_r;
                end
            end else if (accept_s) begin
                if (!head_valid_r) begin
                    head_valid_r <= 1'b1;
                    head_r       <= stg_r;
                end else begin
                    tail_valid_r <= 1'b1;
                    tail_r       <= stg_r;
                end
            end
        end
    end

    // Write-request arbiter: outputs are snapshots taken at grant time.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_req_valid_r <= 1'b0;
            wr_req_addr_r  <= 64'd0;
            wr_req_data_r  <= 64'd0;
            wr_gnt_r       <= {CH_W{1'b0}};
            wr_ptr_r       <= {CH_W{1'b0}};
        end else if (wr_req_valid_r) begin
            if (bus.write_request_ready) begin
                wr_req_valid_r <= 1'b0;
                wr_ptr_r       <= rr_next(wr_gnt_r);
            end
        end else if (wr_pick_s[CH_W]) begin
            wr_req_valid_r <= 1'b1;
            wr_gnt_r       <= wr_pick_s[CH_W-1:0];
            wr_req_addr_r  <= ch_wr_addr_r[wr_pick_s[CH_W-1:0]];
            wr_req_data_r  <= ch_wr_data_r[wr_pick_s[CH_W-1:0]];
        end
    end

    // Read-request arbiter; the tag is the granted channel.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_req_valid_r <= 1'b0;
            rd_req_addr_r  <= 64'd0;
            rd_gnt_r       <= {CH_W{1'b0}};
            rd_ptr_r       <= {CH_W{1'b0}};
        end else if (rd_req_valid_r) begin
            if (bus.read_request_ready) begin
                rd_req_valid_r <= 1'b0;
                rd_ptr_r       <= rr_next(rd_gnt_r);
            end
        end else if (rd_pick_s[CH_W]) begin
            rd_req_valid_r <= 1'b1;
            rd_gnt_r       <= rd_pick_s[CH_W-1:0];
            rd_req_addr_r  <= ch_rd_addr_r[rd_pick_s[CH_W-1:0]];
        end
    end

    // MSI arbiter; vector is the granted channel.
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_valid_r <= 1'b0;
            irq_gnt_r   <= {CH_W{1'b0}};
            irq_ptr_r   <= {CH_W{1'b0}};
        end else if (irq_valid_r) begin
            if (bus.cfg_interrupt_rdy) begin
                irq_valid_r <= 1'b0;
                irq_ptr_r   <= rr_next(irq_gnt_r);
            end
        end else if (irq_pick_s[CH_W]) begin
            irq_valid_r <= 1'b1;
            irq_gnt_r   <= irq_pick_s[CH_W-1:0];
        end
    end

    assign bus.read_completion_valid      = head_valid_r;
    assign bus.read_completion_rid_tag    = head_r.rid;
    assign bus.read_completion_lower_addr = head_r.low;
    assign bus.read_completion_data       = head_r.data;
    assign bus.write_request_valid        = wr_req_valid_r;
    assign bus.write_request_address      = wr_req_addr_r;
    assign bus.write_request_data         = wr_req_data_r;
    assign bus.read_request_valid         = rd_req_valid_r;
    assign bus.read_request_address       = rd_req_addr_r;
    assign bus.read_request_tag           = 8'(rd_gnt_r);
    assign bus.cfg_interrupt              = irq_valid_r;
    assign bus.cfg_interrupt_di           = 8'(irq_gnt_r);
    assign led                            = led_r;
endmodule
